// File: rtl/axil_demux_pkg.sv
// rtl/axil_demux_pkg.sv - response codes and address decode shared by the AXI-lite demux
package axil_demux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_AW = 64;
    localparam int MAX_NS = 16;
    localparam int VEC_W  = MAX_NS * MAX_AW;

    // Flattened vectors use an aw-bit stride; scanning downward lets the lowest match win.
    function automatic int decode(
        input logic [MAX_AW-1:0] addr,
        input logic [VEC_W-1:0]  addr_vec,
        input logic [VEC_W-1:0]  mask_vec,
        input int                aw,
        input int                ns
    );
        logic [MAX_AW-1:0] width_mask;
        logic [MAX_AW-1:0] base;
        logic [MAX_AW-1:0] mask;
        int hit;
        hit = ns;
        width_mask = (aw >= MAX_AW) ? {MAX_AW{1'b1}} : ((MAX_AW'(1) << aw) - MAX_AW'(1));
        for (int i = MAX_NS - 1; i >= 0; i--) begin
            base = MAX_AW'(addr_vec >> (i * aw));
            mask = MAX_AW'(mask_vec >> (i * aw));
            if ((i < ns) && (((addr & mask) & width_mask) == (base & width_mask))) begin
                hit = i;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/axil_demux_chan.sv
// rtl/axil_demux_chan.sv - one request register stage plus outstanding-response counter
module axil_demux_chan
    import axil_demux_pkg::*;
#(
    parameter int PW         = 35,
    parameter int IDXW       = 2,
    parameter int NS         = 2,
    parameter int LANES      = 1,
    parameter int LGMAXBURST = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [IDXW-1:0]       req_idx,
    input  logic [PW-1:0]         req_payload,
    output logic                  req_ready,
    output logic [LANES-1:0]      stage_valid,
    input  logic [LANES-1:0]      stage_ready,
    output logic [PW-1:0]         stage_payload,
    output logic [IDXW-1:0]       idx,
    input  logic                  resp_done,
    output logic                  busy
);

    localparam logic [LGMAXBURST-1:0] CNT_MAX     = '1;
    localparam logic [IDXW-1:0]       IDX_DEFAULT = IDXW'(NS);

    logic [LGMAXBURST-1:0] cnt;
    logic                  accept;

    assign busy = (cnt != '0);

    // Switching targets only when nothing is outstanding keeps responses in order.
    assign req_ready = !rst && (stage_valid == '0) && (cnt != CNT_MAX)
                       && (!busy || (idx == req_idx));
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            idx         <= IDX_DEFAULT;
            cnt         <= '0;
        end else begin
            if (accept) begin
                stage_valid <= '1;
                idx         <= req_idx;
            end else begin
                stage_valid <= stage_valid & ~stage_ready;
            end
            if (accept && !resp_done) begin
                cnt <= cnt + 1'b1;
            end else if (!accept && resp_done) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_payload <= '0;
        end else if (accept) begin
            stage_payload <= req_payload;
        end
    end

endmodule

// File: rtl/axil_decode_demux.sv
// rtl/axil_decode_demux.sv - AXI-lite 1-to-(NS+1) decode demux; AXILDEMUX_INTERNAL_ERR_EN answers unmapped requests internally
module axil_decode_demux
    import axil_demux_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int NS               = 2,
    parameter logic [NS*C_AXI_ADDR_WIDTH-1:0] SLAVE_ADDR = {32'h0000_2000, 32'h0000_1000},
    parameter logic [NS*C_AXI_ADDR_WIDTH-1:0] SLAVE_MASK = {32'h0000_F000, 32'h0000_F000},
    parameter int LGMAXBURST       = 3
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESET,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    output logic [1:0]                         S_AXI_BRESP,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic [NS:0]                        M_AXI_AWVALID,
    input  logic [NS:0]                        M_AXI_AWREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [2:0]                         M_AXI_AWPROT,
    output logic [NS:0]                        M_AXI_WVALID,
    input  logic [NS:0]                        M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    input  logic [NS:0]                        M_AXI_BVALID,
    output logic [NS:0]                        M_AXI_BREADY,
    input  logic [2*(NS+1)-1:0]                M_AXI_BRESP,
    output logic [NS:0]                        M_AXI_ARVALID,
    input  logic [NS:0]                        M_AXI_ARREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [2:0]                         M_AXI_ARPROT,
    input  logic [NS:0]                        M_AXI_RVALID,
    output logic [NS:0]                        M_AXI_RREADY,
    input  logic [C_AXI_DATA_WIDTH*(NS+1)-1:0] M_AXI_RDATA,
    input  logic [2*(NS+1)-1:0]                M_AXI_RRESP
);

    localparam int AW   = C_AXI_ADDR_WIDTH;
    localparam int DW   = C_AXI_DATA_WIDTH;
    localparam int SW   = DW / 8;
    localparam int IDXW = $clog2(NS + 1);
    localparam int WPW  = AW + 3 + DW + SW;
    localparam int RPW  = AW + 3;

    logic [IDXW-1:0] aw_dec, ar_dec, widx, ridx;
    logic            w_req_ready, r_req_ready, w_busy, r_busy;
    logic [1:0]      w_stage_valid, w_stage_ready;
    logic [0:0]      r_stage_valid, r_stage_ready;
    logic [WPW-1:0]  w_payload;
    logic [RPW-1:0]  r_payload;
    logic [NS:0]     wsel, rsel;
    logic            werr, rerr;
    logic            b_done, r_done;

    assign aw_dec = IDXW'(decode(MAX_AW'(S_AXI_AWADDR), VEC_W'(SLAVE_ADDR), VEC_W'(SLAVE_MASK), AW, NS));
    assign ar_dec = IDXW'(decode(MAX_AW'(S_AXI_ARADDR), VEC_W'(SLAVE_ADDR), VEC_W'(SLAVE_MASK), AW, NS));

    // AW and W are taken together so the stage always holds a complete write.
    assign S_AXI_AWREADY = w_req_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign S_AXI_WREADY  = S_AXI_AWREADY;

    axil_demux_chan #(
        .PW(WPW), .IDXW(IDXW), .NS(NS), .LANES(2), .LGMAXBURST(LGMAXBURST)
    ) u_wchan (
        .clk           (S_AXI_ACLK),
        .rst           (S_AXI_ARESET),
        .req_valid     (S_AXI_AWVALID && S_AXI_WVALID),
        .req_idx       (aw_dec),
        .req_payload   ({S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_WDATA, S_AXI_WSTRB}),
        .req_ready     (w_req_ready),
        .stage_valid   (w_stage_valid),
        .stage_ready   (w_stage_ready),
        .stage_payload (w_payload),
        .idx           (widx),
        .resp_done     (b_done),
        .busy          (w_busy)
    );

    axil_demux_chan #(
        .PW(RPW), .IDXW(IDXW), .NS(NS), .LANES(1), .LGMAXBURST(LGMAXBURST)
    ) u_rchan (
        .clk           (S_AXI_ACLK),
        .rst           (S_AXI_ARESET),
        .req_valid     (S_AXI_ARVALID),
        .req_idx       (ar_dec),
        .req_payload   ({S_AXI_ARADDR, S_AXI_ARPROT}),
        .req_ready     (r_req_ready),
        .stage_valid   (r_stage_valid),
        .stage_ready   (r_stage_ready),
        .stage_payload (r_payload),
        .idx           (ridx),
        .resp_done     (r_done),
        .busy          (r_busy)
    );

    assign S_AXI_ARREADY = r_req_ready;
    assign {M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_WDATA, M_AXI_WSTRB} = w_payload;
    assign {M_AXI_ARADDR, M_AXI_ARPROT} = r_payload;

`ifdef AXILDEMUX_INTERNAL_ERR_EN
    assign werr = (widx == IDXW'(NS));
    assign rerr = (ridx == IDXW'(NS));
`else
    assign werr = 1'b0;
    assign rerr = 1'b0;
`endif

    // One-hot port select; the default port drops out when errors are answered internally.
    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int i = 0; i <= NS; i++) begin
            wsel[i] = (widx == IDXW'(i));
            rsel[i] = (ridx == IDXW'(i));
        end
        if (werr) wsel[NS] = 1'b0;
        if (rerr) rsel[NS] = 1'b0;
    end

    assign M_AXI_AWVALID    = wsel & {(NS+1){w_stage_valid[1]}};
    assign M_AXI_WVALID     = wsel & {(NS+1){w_stage_valid[0]}};
    assign w_stage_ready[1] = werr || |(M_AXI_AWREADY & wsel);
    assign w_stage_ready[0] = werr || |(M_AXI_WREADY & wsel);
    assign M_AXI_ARVALID    = rsel & {(NS+1){r_stage_valid[0]}};
    assign r_stage_ready[0] = rerr || |(M_AXI_ARREADY & rsel);

    assign S_AXI_BVALID = w_busy && (werr || |(M_AXI_BVALID & wsel));
    assign M_AXI_BREADY = wsel & {(NS+1){S_AXI_BREADY && w_busy}};
    assign b_done       = S_AXI_BVALID && S_AXI_BREADY;

    assign S_AXI_RVALID = r_busy && (rerr || |(M_AXI_RVALID & rsel));
    assign M_AXI_RREADY = rsel & {(NS+1){S_AXI_RREADY && r_busy}};
    assign r_done       = S_AXI_RVALID && S_AXI_RREADY;

    always_comb begin
        S_AXI_BRESP = RESP_OKAY;
        S_AXI_RRESP = RESP_OKAY;
        S_AXI_RDATA = '0;
        for (int i = 0; i <= NS; i++) begin
            if (wsel[i]) S_AXI_BRESP = M_AXI_BRESP[2*i +: 2];
            if (rsel[i]) begin
                S_AXI_RRESP = M_AXI_RRESP[2*i +: 2];
                S_AXI_RDATA = M_AXI_RDATA[i*DW +: DW];
            end
        end
        if (werr) S_AXI_BRESP = RESP_DECERR;
        if (rerr) S_AXI_RRESP = RESP_DECERR;
    end

endmodule
